// File: rtl/sys_bridge.sv
// sys_bridge: CPU peripheral-port bridge to up to six memory-mapped devices.
// Runs strobe/ack transactions with timeout and owns a maskable interrupt CSR window.
module sys_bridge #(
  parameter int          DEV_NUM     = 6,
  parameter int          DATA_W      = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_7F00,
  parameter int          REGION_BITS = 4,
  parameter int          TIMEOUT_CYC = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               pr_addr,
  input  logic                      pr_we,
  input  logic                      pr_re,
  input  logic [DATA_W-1:0]         pr_wd,
  output logic [DATA_W-1:0]         pr_rd,
  output logic                      pr_ready,
  output logic [REGION_BITS-1:0]    dev_addr,
  output logic [DATA_W-1:0]         dev_wd,
  output logic [DEV_NUM-1:0]        dev_we,
  output logic [DEV_NUM-1:0]        dev_re,
  input  logic [DEV_NUM*DATA_W-1:0] dev_rd,
  input  logic [DEV_NUM-1:0]        dev_ack,
  input  logic [DEV_NUM-1:0]        dev_irq,
  output logic [5:0]                hw_int
);

  localparam int WIN_W = 32 - REGION_BITS;
  localparam int CW    = REGION_BITS - 2;

  localparam logic [WIN_W-1:0]   BASE_WIN     = BASE_ADDR[31:REGION_BITS];
  localparam logic [WIN_W-1:0]   CSR_WIN      = WIN_W'(DEV_NUM);
  localparam logic [CW-1:0]      OFF_MASK     = CW'(0);
  localparam logic [CW-1:0]      OFF_PEND     = CW'(1);
  localparam logic [CW-1:0]      OFF_ERR      = CW'(2);
  localparam logic [7:0]         TO_LAST      = 8'(TIMEOUT_CYC - 1);
  localparam logic [DEV_NUM-1:0] ZERO_DEV     = {DEV_NUM{1'b0}};
  localparam logic [DEV_NUM-1:0] ONES_DEV     = {DEV_NUM{1'b1}};
  localparam logic [DATA_W-1:0]  ZERO_DATA    = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0]  TIMEOUT_DATA = DATA_W'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             state_r;
  logic [DEV_NUM-1:0] sel_oh_r;
  logic               wr_r;
  logic [7:0]         wait_cnt_r;
  logic [DEV_NUM-1:0] mask_r;
  logic [DEV_NUM-1:0] pend_r;
  logic [DEV_NUM-1:0] irq_q_r;
  logic [1:0]         err_r;

  logic [WIN_W-1:0]   win_s;
  logic [CW-1:0]      csr_word_s;
  logic               is_dev_s;
  logic               is_csr_s;
  logic               req_s;
  logic               csr_wr_s;
  logic [DEV_NUM-1:0] dec_oh_s;
  logic [DATA_W-1:0]  csr_rdata_s;
  logic [DEV_NUM-1:0] pend_clr_s;
  logic [DEV_NUM-1:0] pend_set_s;
  logic               sel_ack_s;
  logic [DATA_W-1:0]  sel_rd_s;
  logic [5:0]         int_s;

  // Address decode, CSR read mux and CSR write side effects of the request seen in IDLE
  always_comb begin
    win_s      = pr_addr[31:REGION_BITS] - BASE_WIN;
    csr_word_s = pr_addr[REGION_BITS-1:2];
    is_dev_s   = (win_s < CSR_WIN);
    is_csr_s   = (win_s == CSR_WIN);
    req_s      = (state_r == ST_IDLE) && (pr_we || pr_re);
    csr_wr_s   = req_s && is_csr_s && pr_we;
    dec_oh_s   = ZERO_DEV;
    for (int i = 0; i < DEV_NUM; i++) begin
      dec_oh_s[i] = (win_s == WIN_W'(i));
    end
    case (csr_word_s)
      OFF_MASK: csr_rdata_s = DATA_W'(mask_r);
      OFF_PEND: csr_rdata_s = DATA_W'(pend_r);
      OFF_ERR:  csr_rdata_s = DATA_W'(err_r);
      default:  csr_rdata_s = ZERO_DATA;
    endcase
    pend_clr_s = (csr_wr_s && (csr_word_s == OFF_PEND)) ? pr_wd[DEV_NUM-1:0] : ZERO_DEV;
    pend_set_s = dev_irq & ~irq_q_r;
  end

  // Acknowledge and read data of the channel latched for the current transaction
  always_comb begin
    sel_ack_s = |(dev_ack & sel_oh_r);
    sel_rd_s  = ZERO_DATA;
    for (int i = 0; i < DEV_NUM; i++) begin
      sel_rd_s = sel_rd_s | (dev_rd[i*DATA_W +: DATA_W] & {DATA_W{sel_oh_r[i]}});
    end
  end

  // Masked interrupt vector, zero-padded to the CPU's six lines
  always_comb begin
    int_s              = 6'd0;
    int_s[DEV_NUM-1:0] = pend_r & mask_r;
  end

  // Transaction FSM with registered strobes, read data, ready pulse, MASK and ERR
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      sel_oh_r   <= ZERO_DEV;
      wr_r       <= 1'b0;
      wait_cnt_r <= 8'd0;
      mask_r     <= ONES_DEV;
      err_r      <= 2'b00;
      pr_rd      <= ZERO_DATA;
      pr_ready   <= 1'b0;
      dev_addr   <= {REGION_BITS{1'b0}};
      dev_wd     <= ZERO_DATA;
      dev_we     <= ZERO_DEV;
      dev_re     <= ZERO_DEV;
    end else begin
      pr_ready <= 1'b0;
      dev_we   <= ZERO_DEV;
      dev_re   <= ZERO_DEV;
      case (state_r)
        ST_IDLE: begin
          if (req_s) begin
            wr_r <= pr_we;
            if (is_dev_s) begin
              sel_oh_r <= dec_oh_s;
              dev_addr <= pr_addr[REGION_BITS-1:0];
              dev_wd   <= pr_wd;
              if (pr_we) begin
                dev_we <= dec_oh_s;
              end else begin
                dev_re <= dec_oh_s;
              end
              state_r <= ST_STROBE;
            end else if (is_csr_s) begin
              pr_rd <= pr_we ? ZERO_DATA : csr_rdata_s;
              if (csr_wr_s && (csr_word_s == OFF_MASK)) begin
                mask_r <= pr_wd[DEV_NUM-1:0];
              end else if (csr_wr_s && (csr_word_s == OFF_ERR)) begin
                err_r <= 2'b00;
              end else begin
                mask_r <= mask_r;
              end
              pr_ready <= 1'b1;
              state_r  <= ST_DONE;
            end else begin
              err_r[0] <= 1'b1;
              pr_rd    <= ZERO_DATA;
              pr_ready <= 1'b1;
              state_r  <= ST_DONE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_STROBE: begin
          if (sel_ack_s) begin
            pr_rd    <= wr_r ? ZERO_DATA : sel_rd_s;
            pr_ready <= 1'b1;
            state_r  <= ST_DONE;
          end else begin
            wait_cnt_r <= 8'd0;
            state_r    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // An ack in the final WAIT cycle still completes normally
          if (sel_ack_s) begin
            pr_rd    <= wr_r ? ZERO_DATA : sel_rd_s;
            pr_ready <= 1'b1;
            state_r  <= ST_DONE;
          end else if (wait_cnt_r == TO_LAST) begin
            err_r[1] <= 1'b1;
            pr_rd    <= TIMEOUT_DATA;
            pr_ready <= 1'b1;
            state_r  <= ST_DONE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Interrupt edge capture, pending register (set beats W1C) and registered vector
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_q_r <= ZERO_DEV;
      pend_r  <= ZERO_DEV;
      hw_int  <= 6'd0;
    end else begin
      irq_q_r <= dev_irq;
      pend_r  <= (pend_r & ~pend_clr_s) | pend_set_s;
      hw_int  <= int_s;
    end
  end

endmodule

// File: tb/tb_sys_bridge.sv
// Directed self-checking bench for sys_bridge: scoreboard queue of expected
// completions, a per-transaction device responder and immediate-assertion checks.
module tb_sys_bridge;

  localparam int TO = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  pr_addr;
  logic         pr_we;
  logic         pr_re;
  logic [31:0]  pr_wd;
  logic [31:0]  pr_rd;
  logic         pr_ready;
  logic [3:0]   dev_addr;
  logic [31:0]  dev_wd;
  logic [5:0]   dev_we;
  logic [5:0]   dev_re;
  logic [191:0] dev_rd;
  logic [5:0]   dev_ack;
  logic [5:0]   dev_irq;
  logic [5:0]   hw_int;

  sys_bridge #(
    .DEV_NUM(6), .DATA_W(32), .BASE_ADDR(32'h0000_7F00),
    .REGION_BITS(4), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .pr_addr(pr_addr), .pr_we(pr_we), .pr_re(pr_re), .pr_wd(pr_wd),
    .pr_rd(pr_rd), .pr_ready(pr_ready),
    .dev_addr(dev_addr), .dev_wd(dev_wd), .dev_we(dev_we), .dev_re(dev_re),
    .dev_rd(dev_rd), .dev_ack(dev_ack), .dev_irq(dev_irq), .hw_int(hw_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [5:0]  obs_we;
  logic [5:0]  obs_re;
  int          obs_strobes;
  logic [3:0]  obs_addr;
  logic [31:0] obs_wd;
  logic        ready_seen;

  function automatic logic [31:0] chan_data(input int i);
    return 32'hCAFE_0000 | 32'(i);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One CPU transaction; also plays the addressed device (ack after ack_dly cycles,
  // -1 = never) while every other channel acks continuously and must be ignored.
  task automatic xfer(input string tag, input logic [31:0] addr, input logic we, input logic re,
                      input logic [31:0] wd, input int ack_dly, input logic [5:0] irq,
                      input logic [31:0] exp_rd, input int exp_lat);
    exp_t       e;
    exp_t       got;
    int         lat;
    int         s;
    logic [5:0] smask;
    e.rd  = exp_rd;
    e.lat = exp_lat;
    sb_q.push_back(e);
    obs_we = 6'd0; obs_re = 6'd0; obs_strobes = 0; obs_addr = 4'd0; obs_wd = 32'd0;
    lat = -1; s = -1; smask = 6'd0;
    @(negedge clk);
    pr_addr = addr; pr_we = we; pr_re = re; pr_wd = wd; dev_irq = irq;
    for (int cyc = 1; cyc <= 40 && lat < 0; cyc++) begin
      @(negedge clk);
      if ((dev_we | dev_re) != 6'd0) begin
        obs_strobes++;
        obs_we   = obs_we | dev_we;
        obs_re   = obs_re | dev_re;
        obs_addr = dev_addr;
        obs_wd   = dev_wd;
        if (s < 0) begin
          s     = cyc;
          smask = dev_we | dev_re;
        end
      end
      if (pr_ready) begin
        lat     = cyc;
        dev_ack = 6'd0;
      end else if (s >= 0 && ack_dly >= 0 && cyc == s + ack_dly) begin
        dev_ack = smask;
      end else if (s >= 0) begin
        dev_ack = ~smask;
      end else begin
        dev_ack = 6'd0;
      end
    end
    pr_we = 1'b0; pr_re = 1'b0; dev_ack = 6'd0;
    got = sb_q.pop_front();
    check({tag, "_lat"}, 32'(lat), 32'(got.lat));
    check({tag, "_rd"}, pr_rd, got.rd);
  endtask

  initial begin
    reset = 1'b0; pr_addr = 32'd0; pr_we = 1'b0; pr_re = 1'b0; pr_wd = 32'd0;
    dev_ack = 6'd0; dev_irq = 6'd0;
    for (int i = 0; i < 6; i++) dev_rd[i*32 +: 32] = chan_data(i);

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(pr_ready), 32'd0);
    check("rst_rd", pr_rd, 32'd0);
    check("rst_we", 32'(dev_we), 32'd0);
    check("rst_re", 32'(dev_re), 32'd0);
    check("rst_addr", 32'(dev_addr), 32'd0);
    check("rst_wd", dev_wd, 32'd0);
    check("rst_hw_int", 32'(hw_int), 32'd0);
    reset = 1'b1;

    xfer("mask_rst", 32'h7F60, 1'b0, 1'b1, 32'd0, -1, 6'd0, 32'h0000_003F, 1);

    xfer("wr_dev1", 32'h7F14, 1'b1, 1'b0, 32'hA5A5_0001, 0, 6'd0, 32'd0, 2);
    check("wr_dev1_we", 32'(obs_we), 32'h02);
    check("wr_dev1_re", 32'(obs_re), 32'h00);
    check("wr_dev1_nstb", 32'(obs_strobes), 32'd1);
    check("wr_dev1_addr", 32'(obs_addr), 32'd4);
    check("wr_dev1_wd", obs_wd, 32'hA5A5_0001);

    xfer("rd_dev1", 32'h7F14, 1'b0, 1'b1, 32'd0, 0, 6'd0, chan_data(1), 2);
    check("rd_dev1_re", 32'(obs_re), 32'h02);
    check("rd_dev1_we", 32'(obs_we), 32'h00);

    xfer("rd_dev2_n5", 32'h7F28, 1'b0, 1'b1, 32'd0, 5, 6'd0, chan_data(2), 7);
    check("rd_dev2_nstb", 32'(obs_strobes), 32'd1);
    check("rd_dev2_addr", 32'(obs_addr), 32'd8);

    xfer("rd_dev3_last", 32'h7F30, 1'b0, 1'b1, 32'd0, TO, 6'd0, chan_data(3), 2 + TO);
    xfer("rd_dev4_to", 32'h7F40, 1'b0, 1'b1, 32'd0, -1, 6'd0, 32'hDEAD_BEEF, 2 + TO);
    xfer("err_to", 32'h7F68, 1'b0, 1'b1, 32'd0, -1, 6'd0, 32'h2, 1);
    xfer("err_clr_wr", 32'h7F68, 1'b1, 1'b0, 32'd0, -1, 6'd0, 32'd0, 1);
    xfer("err_clr_rd", 32'h7F68, 1'b0, 1'b1, 32'd0, -1, 6'd0, 32'd0, 1);

    xfer("unmap_rd", 32'h0000_1000, 1'b0, 1'b1, 32'd0, -1, 6'd0, 32'd0, 1);
    check("unmap_nstb", 32'(obs_strobes), 32'd0);
    xfer("err_unmap", 32'h7F68, 1'b0, 1'b1, 32'd0, -1, 6'd0, 32'h1, 1);
    xfer("unmap_win7", 32'h7F70, 1'b1, 1'b0, 32'h1234, -1, 6'd0, 32'd0, 1);
    xfer("err_wr", 32'h7F68, 1'b1, 1'b0, 32'hFFFF_FFFF, -1, 6'd0, 32'd0, 1);
    xfer("err_rd0", 32'h7F68, 1'b0, 1'b1, 32'd0, -1, 6'd0, 32'd0, 1);
    xfer("csr_off3", 32'h7F6C, 1'b0, 1'b1, 32'd0, -1, 6'd0, 32'd0, 1);

    xfer("wr_rd_dev5", 32'h7F5C, 1'b1, 1'b1, 32'h5555_AAAA, 0, 6'd0, 32'd0, 2);
    check("wr_rd_dev5_we", 32'(obs_we), 32'h20);
    check("wr_rd_dev5_re", 32'(obs_re), 32'h00);
    check("wr_rd_dev5_addr", 32'(obs_addr), 32'd12);

    @(negedge clk); dev_irq = 6'b000001;
    @(negedge clk); dev_irq = 6'd0;
    check("irq_c1", 32'(hw_int), 32'd0);
    @(negedge clk);
    check("irq_c2", 32'(hw_int), 32'h01);
    xfer("pend_rd", 32'h7F64, 1'b0, 1'b1, 32'd0, -1, 6'd0, 32'h1, 1);
    xfer("mask_wr0", 32'h7F60, 1'b1, 1'b0, 32'd0, -1, 6'd0, 32'd0, 1);
    @(negedge clk);
    check("hw_int_masked", 32'(hw_int), 32'd0);
    xfer("pend_masked", 32'h7F64, 1'b0, 1'b1, 32'd0, -1, 6'd0, 32'h1, 1);
    xfer("pend_w1c_race", 32'h7F64, 1'b1, 1'b0, 32'h1, -1, 6'b000001, 32'd0, 1);
    xfer("pend_race_rd", 32'h7F64, 1'b0, 1'b1, 32'd0, -1, 6'd0, 32'h1, 1);
    xfer("pend_w1c", 32'h7F64, 1'b1, 1'b0, 32'h1, -1, 6'd0, 32'd0, 1);
    xfer("pend_clr_rd", 32'h7F64, 1'b0, 1'b1, 32'd0, -1, 6'd0, 32'd0, 1);
    xfer("mask_rd0", 32'h7F60, 1'b0, 1'b1, 32'd0, -1, 6'd0, 32'd0, 1);

    @(negedge clk); pr_addr = 32'h7F30; pr_re = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_ready", 32'(pr_ready), 32'd0);
    reset = 1'b0; pr_re = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", 32'(pr_ready), 32'd0);
    check("rst_mid_stb", 32'(dev_we | dev_re), 32'd0);
    reset = 1'b1;
    ready_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (pr_ready) ready_seen = 1'b1;
    end
    check("rst_no_ready", 32'(ready_seen), 32'd0);
    xfer("rd_after_rst", 32'h7F14, 1'b0, 1'b1, 32'd0, 0, 6'd0, chan_data(1), 2);
    xfer("mask_after_rst", 32'h7F60, 1'b0, 1'b1, 32'd0, -1, 6'd0, 32'h0000_003F, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
